mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_ctrl_pkg.sv | 33 +++
 rtl/mem_read_align.sv | 23 ++
 rtl/mem_access_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the CPU-to-memory access controller: size codes,
// FSM states, default timeout and the alignment rule.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    SIZE_WORD  = 2'b00,
    SIZE_BYTE  = 2'b01,
    SIZE_HALF  = 2'b10,
    SIZE_DWORD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_GAP,
    ST_RESP
  } state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 15;

  function automatic logic is_aligned(input size_e size, input logic [2:0] addr_lo);
    logic ok;
    case (size)
      SIZE_BYTE:  ok = 1'b1;
      SIZE_HALF:  ok = (addr_lo[0] == 1'b0);
      SIZE_WORD:  ok = (addr_lo[1:0] == 2'b00);
      SIZE_DWORD: ok = (addr_lo == 3'b000);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_read_align.sv
// Formats captured memory beats into the 64-bit read result by request size.
module mem_read_align
  import mem_ctrl_pkg::*;
(
  input  size_e       size_i,
  input  logic [31:0] beat0_i,
  input  logic [31:0] beat1_i,
  output logic [63:0] rdata_o
);

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    rdata_o = '0;
    case (size_i)
      SIZE_BYTE:  rdata_o = {56'd0, beat0_i[7:0]};
      SIZE_HALF:  rdata_o = {48'd0, beat0_i[15:0]};
      SIZE_WORD:  rdata_o = {32'd0, beat0_i};
      SIZE_DWORD: rdata_o = {beat1_i, beat0_i};
      default:    rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences CPU requests onto a strobe/complete memory bus, splitting
// doublewords into two 32-bit beats separated by a mandatory idle cycle.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mem_enable,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_wsel,
  input  logic [31:0] mem_rdata,
  input  logic        mem_mfc
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e             state_q, state_d;
  size_e              size_q, size_d;
  logic               rw_q, rw_d;
  logic               beat_q, beat_d;
  logic               err_q, err_d;
  logic [31:0]        wdata_hi_q, wdata_hi_d;
  logic [31:0]        beat0_q, beat0_d;
  logic [31:0]        beat1_q, beat1_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [63:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_error_q, rsp_error_d;
  logic               mem_enable_q, mem_enable_d;
  logic               mem_rw_q, mem_rw_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [1:0]         mem_wsel_q, mem_wsel_d;
  logic [63:0]        fmt_rdata;
  size_e              req_size_e;

  assign req_size_e = size_e'(req_size);

  mem_read_align u_read_align (
    .size_i  (size_q),
    .beat0_i (beat0_q),
    .beat1_i (beat1_q),
    .rdata_o (fmt_rdata)
  );

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    rw_d         = rw_q;
    beat_d       = beat_q;
    err_d        = err_q;
    wdata_hi_d   = wdata_hi_q;
    beat0_d      = beat0_q;
    beat1_d      = beat1_q;
    wait_cnt_d   = wait_cnt_q;
    req_ready_d  = req_ready_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_error_d  = 1'b0;
    mem_enable_d = mem_enable_q;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wsel_d   = mem_wsel_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          size_d      = req_size_e;
          rw_d        = req_rw;
          wdata_hi_d  = req_wdata[63:32];
          beat_d      = 1'b0;
          err_d       = 1'b0;
          req_ready_d = 1'b0;
          if (is_aligned(req_size_e, req_addr[2:0])) begin
            state_d      = ST_ACCESS;
            mem_enable_d = 1'b1;
            mem_rw_d     = req_rw;
            mem_addr_d   = req_addr;
            mem_wdata_d  = req_wdata[31:0];
            mem_wsel_d   = (req_size_e == SIZE_DWORD) ? SIZE_WORD : req_size;
            wait_cnt_d   = '0;
          end else begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_mfc) begin
          state_d      = ST_GAP;
          mem_enable_d = 1'b0;
          if (beat_q) beat1_d = mem_rdata;
          else        beat0_d = mem_rdata;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d      = ST_GAP;
          mem_enable_d = 1'b0;
          err_d        = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        // A timed-out first beat drops the second beat entirely.
        if (size_q == SIZE_DWORD && !beat_q && !err_q) begin
          state_d      = ST_ACCESS;
          mem_enable_d = 1'b1;
          mem_addr_d   = mem_addr_q + 32'd4;
          mem_wdata_d  = wdata_hi_q;
          beat_d       = 1'b1;
          wait_cnt_d   = '0;
        end else begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_error_d = err_q;
          rsp_rdata_d = (err_q || !rw_q) ? 64'd0 : fmt_rdata;
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      size_q       <= SIZE_WORD;
      rw_q         <= 1'b1;
      beat_q       <= 1'b0;
      err_q        <= 1'b0;
      wdata_hi_q   <= '0;
      beat0_q      <= '0;
      beat1_q      <= '0;
      wait_cnt_q   <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_error_q  <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_rw_q     <= 1'b1;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wsel_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      rw_q         <= rw_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      wdata_hi_q   <= wdata_hi_d;
      beat0_q      <= beat0_d;
      beat1_q      <= beat1_d;
      wait_cnt_q   <= wait_cnt_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_error_q  <= rsp_error_d;
      mem_enable_q <= mem_enable_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wsel_q   <= mem_wsel_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_error  = rsp_error_q;
  assign mem_enable = mem_enable_q;
  assign mem_rw     = mem_rw_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wsel   = mem_wsel_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl; inputs change and outputs are sampled on the falling edge.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_enable;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_wsel;
  logic [31:0] mem_rdata;
  logic        mem_mfc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rw     (req_rw),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .mem_enable (mem_enable),
    .mem_rw     (mem_rw),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wsel   (mem_wsel),
    .mem_rdata  (mem_rdata),
    .mem_mfc    (mem_mfc)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic rw, input logic [1:0] size, input logic [31:0] addr,
                       input logic [63:0] wdata);
    req_valid = 1'b1;
    req_rw    = rw;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "simulation did not terminate");
  end

  initial begin
    int en_cnt;
    logic saw_rsp;

    rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b1; req_size = 2'b00;
    req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_mfc = 1'b0;
    repeat (3) step();

    // Reset values
    check("rst_enable", mem_enable, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_error", rsp_error, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 64'h0);
    check("rst_mem_rw", mem_rw, 1'b1);
    check("rst_mem_wsel", mem_wsel, 2'b00);
    rst_n = 1'b1;
    step();
    check("rst_req_ready", req_ready, 1'b1);

    // Byte write at 0x3, completion in the second ACCESS cycle
    issue(1'b0, 2'b01, 32'h0000_0003, 64'h0000_0000_0000_00A5);
    step();
    req_valid = 1'b0;
    check("bw_enable1", mem_enable, 1'b1);
    check("bw_rw", mem_rw, 1'b0);
    check("bw_wsel", mem_wsel, 2'b01);
    check("bw_addr", mem_addr, 32'h3);
    check("bw_wdata", mem_wdata, 32'hA5);
    check("bw_ready_busy", req_ready, 1'b0);
    step();
    check("bw_enable2", mem_enable, 1'b1);
    mem_mfc = 1'b1;
    step();
    mem_mfc = 1'b0;
    check("bw_gap", mem_enable, 1'b0);
    check("bw_gap_novalid", rsp_valid, 1'b0);
    step();
    check("bw_rsp_valid", rsp_valid, 1'b1);
    check("bw_rsp_error", rsp_error, 1'b0);
    check("bw_rsp_rdata", rsp_rdata, 64'h0);
    step();
    check("bw_rsp_pulse", rsp_valid, 1'b0);
    check("bw_ready_back", req_ready, 1'b1);

    // Word read at 0x10, completion in the first ACCESS cycle
    issue(1'b1, 2'b00, 32'h0000_0010, 64'h0);
    step();
    req_valid = 1'b0;
    check("wr_enable", mem_enable, 1'b1);
    check("wr_rw", mem_rw, 1'b1);
    check("wr_addr", mem_addr, 32'h10);
    check("wr_wsel", mem_wsel, 2'b00);
    mem_mfc = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_mfc = 1'b0; mem_rdata = 32'h0;
    check("wr_gap", mem_enable, 1'b0);
    step();
    check("wr_rsp_valid", rsp_valid, 1'b1);
    check("wr_rsp_rdata", rsp_rdata, 64'h0000_0000_DEAD_BEEF);
    check("wr_rsp_error", rsp_error, 1'b0);
    step();
    check("wr_rsp_pulse", rsp_valid, 1'b0);

    // Doubleword read at 0x08, two beats
    issue(1'b1, 2'b11, 32'h0000_0008, 64'h0);
    step();
    req_valid = 1'b0;
    check("dr_b1_enable", mem_enable, 1'b1);
    check("dr_b1_addr", mem_addr, 32'h08);
    check("dr_b1_wsel", mem_wsel, 2'b00);
    mem_mfc = 1'b1; mem_rdata = 32'h1111_1111;
    step();
    mem_mfc = 1'b0; mem_rdata = 32'h0;
    check("dr_gap_enable", mem_enable, 1'b0);
    check("dr_gap_novalid", rsp_valid, 1'b0);
    step();
    check("dr_b2_enable", mem_enable, 1'b1);
    check("dr_b2_addr", mem_addr, 32'h0C);
    mem_mfc = 1'b1; mem_rdata = 32'h2222_2222;
    step();
    mem_mfc = 1'b0; mem_rdata = 32'h0;
    check("dr_gap2_enable", mem_enable, 1'b0);
    step();
    check("dr_rsp_valid", rsp_valid, 1'b1);
    check("dr_rsp_rdata", rsp_rdata, 64'h2222_2222_1111_1111);
    check("dr_rsp_error", rsp_error, 1'b0);
    step();

    // Doubleword write: low word first, high word second beat
    issue(1'b0, 2'b11, 32'h0000_0020, 64'hCAFE_BABE_1234_5678);
    step();
    req_valid = 1'b0;
    check("dw_b1_wdata", mem_wdata, 32'h1234_5678);
    mem_mfc = 1'b1;
    step();
    mem_mfc = 1'b0;
    step();
    check("dw_b2_wdata", mem_wdata, 32'hCAFE_BABE);
    check("dw_b2_addr", mem_addr, 32'h24);
    check("dw_b2_rw", mem_rw, 1'b0);
    mem_mfc = 1'b1;
    step();
    mem_mfc = 1'b0;
    step();
    check("dw_rsp_valid", rsp_valid, 1'b1);
    check("dw_rsp_rdata", rsp_rdata, 64'h0);
    step();

    // Byte read at 0x5; mfc high while still IDLE must be ignored
    issue(1'b1, 2'b01, 32'h0000_0005, 64'h0);
    mem_mfc = 1'b1;
    step();
    req_valid = 1'b0;
    mem_mfc = 1'b0;
    check("br_enable1", mem_enable, 1'b1);
    step();
    check("br_enable2", mem_enable, 1'b1);
    mem_mfc = 1'b1; mem_rdata = 32'hFFFF_FF80;
    step();
    mem_mfc = 1'b0; mem_rdata = 32'h0;
    step();
    check("br_rsp_valid", rsp_valid, 1'b1);
    check("br_rsp_rdata", rsp_rdata, 64'h80);
    step();

    // Halfword read at 0x2, upper half discarded
    issue(1'b1, 2'b10, 32'h0000_0002, 64'h0);
    step();
    req_valid = 1'b0;
    check("hr_wsel", mem_wsel, 2'b10);
    mem_mfc = 1'b1; mem_rdata = 32'hABCD_1234;
    step();
    mem_mfc = 1'b0; mem_rdata = 32'h0;
    step();
    check("hr_rsp_rdata", rsp_rdata, 64'h1234);
    step();

    // Misaligned halfword read at 0x1
    issue(1'b1, 2'b10, 32'h0000_0001, 64'h0);
    step();
    req_valid = 1'b0;
    check("mis_enable", mem_enable, 1'b0);
    check("mis_rsp_valid", rsp_valid, 1'b1);
    check("mis_rsp_error", rsp_error, 1'b1);
    check("mis_rsp_rdata", rsp_rdata, 64'h0);
    step();
    check("mis_rsp_pulse", rsp_valid, 1'b0);
    check("mis_enable_after", mem_enable, 1'b0);
    check("mis_ready", req_ready, 1'b1);

    // Word read timeout, mfc held low
    issue(1'b1, 2'b00, 32'h0000_0040, 64'h0);
    mem_rdata = 32'h5555_5555;
    en_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      req_valid = 1'b0;
      if (mem_enable) en_cnt++;
      else break;
    end
    check("to_enable_cycles", 64'(en_cnt), 64'd15);
    step();
    check("to_rsp_valid", rsp_valid, 1'b1);
    check("to_rsp_error", rsp_error, 1'b1);
    check("to_rsp_rdata", rsp_rdata, 64'h0);
    step();
    mem_rdata = 32'h0;

    // Doubleword timeout on first beat drops the second beat
    issue(1'b1, 2'b11, 32'h0000_0030, 64'h0);
    en_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      req_valid = 1'b0;
      if (mem_enable) en_cnt++;
      else break;
    end
    check("dto_enable_cycles", 64'(en_cnt), 64'd15);
    step();
    check("dto_no_beat2", mem_enable, 1'b0);
    check("dto_rsp_valid", rsp_valid, 1'b1);
    check("dto_rsp_error", rsp_error, 1'b1);
    step();

    // Reset during the second beat of a doubleword read
    issue(1'b1, 2'b11, 32'h0000_0008, 64'h0);
    step();
    req_valid = 1'b0;
    mem_mfc = 1'b1; mem_rdata = 32'h3333_3333;
    step();
    mem_mfc = 1'b0;
    step();
    check("rr_b2_enable", mem_enable, 1'b1);
    rst_n = 1'b0;
    step();
    check("rr_enable_low", mem_enable, 1'b0);
    check("rr_no_valid", rsp_valid, 1'b0);
    rst_n = 1'b1;
    step();
    check("rr_ready", req_ready, 1'b1);
    saw_rsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid || mem_enable) saw_rsp = 1'b1;
    end
    check("rr_quiet", saw_rsp, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
